// File: rtl/counter_ctrl.sv
// Loadable up/down counter controller with wrap / one-shot modes, a registered
// terminal-count pulse and a sticky overflow flag. Sequenced by an IDLE/RUN/DONE FSM.
module counter_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAXV  = 9,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_dn_i,
  input  logic             mode_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam logic [WIDTH-1:0] MaxV  = WIDTH'(MAXV);
  localparam logic [WIDTH-1:0] InitV = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] One   = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_term;
  logic             wrap;

  // State and datapath registers; async active-low reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      count_q <= InitV;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state / next count, priority load > stop > start > count step.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    wrap    = 1'b0;
    // Terminal depends on the direction requested for this step.
    at_term = up_dn_i ? (count_q == MaxV) : (count_q == '0);

    if (load_i) begin
      count_d = (load_val_i > MaxV) ? MaxV : load_val_i;
    end else if (stop_i) begin
      if (state_q == StRun) begin
        state_d = StIdle;
      end
    end else if (start_i && (state_q != StRun)) begin
      state_d = StRun;
      if (state_q == StDone) begin
        count_d = InitV;
      end
    end else if ((state_q == StRun) && en_i) begin
      if (!at_term) begin
        count_d = up_dn_i ? (count_q + One) : (count_q - One);
      end else if (!mode_i) begin
        count_d = up_dn_i ? '0 : MaxV;
        tc_d    = 1'b1;
        wrap    = 1'b1;
      end else begin
        // One-shot: hold at terminal and finish.
        tc_d    = 1'b1;
        state_d = StDone;
      end
    end
  end

  // Sticky overflow: a wrap in the same cycle beats a clear request.
  always_comb begin
    ovf_d = ovf_q;
    if (wrap) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    count_o = count_q;
    tc_o    = tc_q;
    busy_o  = (state_q == StRun);
    ovf_o   = ovf_q;
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus a randomized run, checked
// against a modular-arithmetic reference model.
module tb_counter_ctrl;

  localparam int W    = 4;
  localparam int MAXV = 9;
  localparam int INIT = 0;

  logic         clk = 1'b0;
  logic         rstb;
  logic         en, start, stop, load, up_dn, mode, clr_ovf;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc, busy, ovf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_count;
  bit m_run, m_done, m_tc, m_ovf;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(W), .MAXV(MAXV), .INIT(INIT)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en_i      (en),
    .start_i   (start),
    .stop_i    (stop),
    .load_i    (load),
    .load_val_i(load_val),
    .up_dn_i   (up_dn),
    .mode_i    (mode),
    .clr_ovf_i (clr_ovf),
    .count_o   (count),
    .tc_o      (tc),
    .busy_o    (busy),
    .ovf_o     (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = INIT;
    m_run   = 0;
    m_done  = 0;
    m_tc    = 0;
    m_ovf   = 0;
  endtask

  // Count space is the ring 0..MAXV; a step moves +1 or -1 around it.
  task automatic model_step();
    int term;
    bit wrapped;
    wrapped = 0;
    m_tc    = 0;
    if (load) begin
      m_count = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
    end else if (stop) begin
      m_run = 0;
    end else if (start && !m_run) begin
      if (m_done) m_count = INIT;
      m_run  = 1;
      m_done = 0;
    end else if (m_run && en) begin
      term = up_dn ? MAXV : 0;
      if (m_count == term) begin
        m_tc = 1;
        if (mode) begin
          m_run  = 0;
          m_done = 1;
        end else begin
          wrapped = 1;
        end
      end
      if (!(m_count == term && mode)) m_count = (m_count + (up_dn ? 1 : MAXV)) % (MAXV + 1);
    end
    if (wrapped) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".tc"},    32'(tc),    32'(m_tc));
    check({tag, ".busy"},  32'(busy),  32'(m_run));
    check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
  endtask

  // One clock: inputs were set away from the edge; update model, then sample.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic quiet();
    en = 0; start = 0; stop = 0; load = 0; clr_ovf = 0; load_val = '0;
  endtask

  initial begin
    int tc_seen;
    quiet();
    up_dn = 1; mode = 0;
    rstb = 1'b0;
    model_reset();
    #3;
    check_all("reset_init");
    @(posedge clk);
    #1 rstb = 1'b1;

    // Wrap up: 12 enabled cycles -> 1..9,0,1,2
    start = 1;
    cyc("wrap_start");
    start = 0; en = 1; tc_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc("wrap_run");
      if (tc === 1'b1) tc_seen++;
    end
    check("wrap_final_count", 32'(count), 32'd2);
    check("wrap_tc_pulses", 32'(tc_seen), 32'd1);
    check("wrap_ovf", 32'(ovf), 32'd1);
    check("wrap_busy", 32'(busy), 32'd1);

    // Async reset mid-count at 5
    repeat (3) cyc("pre_reset");
    check("pre_reset_count", 32'(count), 32'd5);
    #2 rstb = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_tc", 32'(tc), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rstb = 1'b1;
    quiet();

    // One-shot down from 3
    load = 1; load_val = 4'd3; up_dn = 0; mode = 1;
    cyc("os_load");
    load = 0; start = 1;
    cyc("os_start");
    start = 0; en = 1; tc_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc("os_run");
      if (tc === 1'b1) tc_seen++;
    end
    check("os_count", 32'(count), 32'd0);
    check("os_busy", 32'(busy), 32'd0);
    check("os_ovf", 32'(ovf), 32'd0);
    check("os_tc_pulses", 32'(tc_seen), 32'd1);
    en = 0; start = 1;
    cyc("os_restart");
    check("os_restart_count", 32'(count), 32'(INIT));
    check("os_restart_busy", 32'(busy), 32'd1);

    // Clamp and priority over start
    start = 0; stop = 1;
    cyc("clamp_stop");
    stop = 0; load = 1; load_val = 4'd15; start = 1; en = 1; up_dn = 1; mode = 0;
    cyc("clamp_load");
    check("clamp_count", 32'(count), 32'd9);
    check("clamp_busy", 32'(busy), 32'd0);
    load = 0;
    cyc("clamp_start");
    check("clamp_start_busy", 32'(busy), 32'd1);
    check("clamp_start_count", 32'(count), 32'd9);

    // Wrap beats clr_ovf; then clear; stop beats en
    start = 0; en = 1; clr_ovf = 1;
    cyc("sim_wrap");
    check("sim_wrap_ovf", 32'(ovf), 32'd1);
    check("sim_wrap_tc", 32'(tc), 32'd1);
    en = 0;
    cyc("sim_clr");
    check("sim_clr_ovf", 32'(ovf), 32'd0);
    clr_ovf = 0; stop = 1; en = 1;
    cyc("sim_stop");
    check("sim_stop_count", 32'(count), 32'd0);
    check("sim_stop_busy", 32'(busy), 32'd0);

    // en gating with a direction flip
    quiet();
    up_dn = 1; start = 1;
    cyc("gate_start");
    start = 0;
    for (int i = 0; i < 8; i++) begin
      en = (i % 2 == 0);
      if (i == 6) up_dn = 0;
      cyc("gate_run");
    end
    check("gate_count", 32'(count), 32'd2);
    check("gate_busy", 32'(busy), 32'd1);

    // Randomized traffic against the model
    quiet();
    for (int i = 0; i < 600; i++) begin
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom);
      stop     = ($urandom_range(0, 11) == 0);
      start    = ($urandom_range(0, 3) == 0);
      en       = ($urandom_range(0, 3) != 0);
      clr_ovf  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
